// File: rtl/pixel_write_queue_pkg.sv
// pixel_write_queue_pkg: shared widths, colours, FSM encoding and screen size for the pixel path
package pixel_write_queue_pkg;
    localparam int COORD_W  = 7;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 128;
    localparam int SCREEN_H = 120;
    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;
    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [COLOUR_W-1:0] c;
    } pixel_t;
endpackage

// File: rtl/pixel_write_queue_fifo.sv
// pixel_fifo: circular pixel buffer with count-based full/empty
//   clk, resetn      clock, async active-low reset
//   push, din        write request and data (dropped when full)
//   pop, dout        read request and head-of-queue data (ignored when empty)
//   full, empty      occupancy flags derived from the registered count
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 17
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/pixel_write_queue.sv
// pixel_write_queue: buffers pixel writes for the VGA adapter and sweeps the screen black
//   clk, resetn             clock, async active-low reset
//   wr_en, x_in, y_in, c_in pixel write from the drawing datapath
//   clr_start               one-cycle request for a full-screen black sweep
//   x_out, y_out, c_out     registered pixel to the adapter, qualified by plot
//   full, empty             FIFO occupancy
//   overflow                sticky dropped-write flag
//   clr_busy                high while sweep pixels are on the outputs
module pixel_write_queue
    import pixel_write_queue_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int WIDTH          = SCREEN_W,
    parameter int HEIGHT         = SCREEN_H,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr_en,
    input  logic [COORD_W-1:0]  x_in,
    input  logic [COORD_W-1:0]  y_in,
    input  logic [COLOUR_W-1:0] c_in,
    input  logic                clr_start,
    output logic [COORD_W-1:0]  x_out,
    output logic [COORD_W-1:0]  y_out,
    output logic [COLOUR_W-1:0] c_out,
    output logic                plot,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                clr_busy
);
    localparam logic [0:0] RST_STATE = CLEAR_ON_RESET ? S_SWEEP : S_IDLE;
    logic [0:0]         state_q, state_d;
    logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
    pixel_t             pix_q, pix_d, din, dout;
    logic               plot_q, ovf_q, busy_q;
    logic               sweeping, row_end, last, pop;
    assign din      = '{x: x_in, y: y_in, c: c_in};
    assign sweeping = state_q == S_SWEEP;
    assign row_end  = sx_q == COORD_W'(WIDTH - 1);
    assign last     = row_end && sy_q == COORD_W'(HEIGHT - 1);
    assign pop      = !sweeping && !empty;
    pixel_fifo #(.DEPTH(DEPTH), .DW($bits(pixel_t))) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (wr_en),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        state_d = sweeping ? (last ? S_IDLE : S_SWEEP) : (clr_start ? S_SWEEP : S_IDLE);
        sx_d    = (sweeping && !row_end) ? sx_q + 1'b1 : '0;
        sy_d    = (sweeping && !last) ? sy_q + COORD_W'(row_end) : '0;
        pix_d   = sweeping ? '{x: sx_q, y: sy_q, c: BLACK} : (pop ? dout : pix_q);
    end
    // clr_busy follows the state one cycle late so it covers exactly the cycles showing sweep pixels
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RST_STATE;
            sx_q    <= '0;
            sy_q    <= '0;
            pix_q   <= '0;
            plot_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            pix_q   <= pix_d;
            plot_q  <= sweeping || pop;
            ovf_q   <= ovf_q || (wr_en && full);
            busy_q  <= sweeping;
        end
    end
    assign x_out    = pix_q.x;
    assign y_out    = pix_q.y;
    assign c_out    = pix_q.c;
    assign plot     = plot_q;
    assign overflow = ovf_q;
    assign clr_busy = busy_q;
endmodule

// File: tb/tb_pixel_write_queue.sv
// tb_pixel_write_queue: scoreboard bench for the pixel write queue and screen sweeper
module tb_pixel_write_queue;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [6:0] x_in = '0, y_in = '0;
    logic [2:0] c_in = '0;
    logic       clr_start = 1'b0;
    logic [6:0] x_out, y_out;
    logic [2:0] c_out;
    logic       plot, full, empty, overflow, clr_busy;
    int         n_tests = 0, n_fail = 0;
    int         plots = 0, sweep_plots = 0;
    logic [16:0] sb [$];

    pixel_write_queue dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .x_in     (x_in),
        .y_in     (y_in),
        .c_in     (c_in),
        .clr_start(clr_start),
        .x_out    (x_out),
        .y_out    (y_out),
        .c_out    (c_out),
        .plot     (plot),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_busy (clr_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_sweep();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 128; x++)
                sb.push_back({7'(x), 7'(y), 3'b000});
    endtask

    task automatic drive(input int x, input int y, input int c, input bit expect_plot);
        wr_en = 1'b1;
        x_in  = 7'(x);
        y_in  = 7'(y);
        c_in  = 3'(c);
        if (expect_plot) sb.push_back({7'(x), 7'(y), 3'(c)});
    endtask

    task automatic wait_sweep_done(input int base);
        int i;
        for (i = 0; i < 20000 && clr_busy; i++) tick();
        chk("sweep_terminates", int'(clr_busy), 0);
        chk("sweep_plot_count", sweep_plots - base, 15360);
    endtask

    task automatic wait_sb_empty(input string nm, input int lim);
        int i;
        for (i = 0; i < lim && sb.size() != 0; i++) tick();
        chk(nm, sb.size(), 0);
    endtask

    // monitor: every plot cycle must match the head of the scoreboard
    initial begin
        logic [16:0] exp;
        forever begin
            @(negedge clk);
            if (resetn && plot) begin
                plots++;
                if (clr_busy) sweep_plots++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d with nothing expected", x_out, y_out, c_out);
                end else begin
                    exp = sb.pop_front();
                    chk("plot_pixel", int'({x_out, y_out, c_out}), int'(exp));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int base, p0;
        // reset values
        tick();
        tick();
        chk("rst_plot", int'(plot), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_clr_busy", int'(clr_busy), 1);
        chk("rst_xyc", int'({x_out, y_out, c_out}), 0);
        // power-up sweep, with 16 pushes filling the FIFO and a 17th dropped
        expect_sweep();
        base = sweep_plots;
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(i, 0, 2, 1'b1);
            tick();
        end
        drive(16, 1, 7, 1'b0);
        tick();
        wr_en = 1'b0;
        chk("sweep_full", int'(full), 1);
        chk("sweep_overflow", int'(overflow), 1);
        chk("sweep_busy", int'(clr_busy), 1);
        wait_sweep_done(base);
        wait_sb_empty("drain_16", 100);
        tick();
        chk("post_drain_plot", int'(plot), 0);
        chk("post_drain_empty", int'(empty), 1);
        // single push into an empty idle queue: one-cycle latency
        drive(5, 9, 5, 1'b1);
        tick();
        wr_en = 1'b0;
        chk("single_not_yet", int'(plot), 0);
        chk("single_queued", int'(empty), 0);
        tick();
        chk("single_plot", int'(plot), 1);
        chk("single_empty", int'(empty), 1);
        tick();
        chk("single_once", int'(plot), 0);
        // clr_start with a pop in flight: A plots, sweep runs, then B and C
        drive(1, 2, 3, 1'b1);
        tick();
        sb.push_back({7'd0, 7'd0, 3'd0});
        sb.pop_back();
        expect_sweep();
        base = sweep_plots;
        drive(4, 5, 6, 1'b1);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        drive(7, 8, 1, 1'b1);
        tick();
        wr_en = 1'b0;
        chk("clr_busy_started", int'(clr_busy), 1);
        for (int i = 0; i < 10; i++) begin
            drive(20 + i, 50, i % 8, 1'b1);
            tick();
        end
        wr_en = 1'b0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wait_sweep_done(base);
        // asynchronous reset midway through the 10-entry drain
        for (int i = 0; i < 200 && sb.size() > 5; i++) tick();
        chk("drain_mid_reached", int'(sb.size() <= 5), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_plot", int'(plot), 0);
        chk("async_empty", int'(empty), 1);
        chk("async_overflow", int'(overflow), 0);
        chk("async_clr_busy", int'(clr_busy), 1);
        sb.delete();
        tick();
        expect_sweep();
        base = sweep_plots;
        resetn = 1'b1;
        wait_sweep_done(base);
        wait_sb_empty("post_reset_sweep", 10);
        // continuous pushes in idle: drain keeps pace, nothing dropped
        tick();
        p0 = plots;
        for (int i = 0; i < 40; i++) begin
            drive(i, (i * 3) % 120, i % 8, 1'b1);
            tick();
            chk("stream_not_full", int'(full), 0);
        end
        wr_en = 1'b0;
        wait_sb_empty("stream_drain", 10);
        tick();
        chk("stream_plots", plots - p0, 40);
        chk("stream_overflow", int'(overflow), 0);
        chk("stream_empty", int'(empty), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_write_queue.md
Name: pixel_write_queue

Overview:
- Sits directly downstream of the box-drawing datapath and upstream of the VGA adapter.
- Accepts (x, y, colour) pixel writes from the drawing datapath into a small FIFO and replays them to the adapter, one pixel per cycle.
- Contains a screen-clear sweeper that rasters black over the whole frame, at power-up and on request.
- Decouples the drawing FSMs from adapter timing and gives one point to observe dropped writes.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2).
- WIDTH, 128, sweep columns (x range 0..WIDTH-1, must fit 7 bits).
- HEIGHT, 120, sweep rows (y range 0..HEIGHT-1, must fit 7 bits).
- CLEAR_ON_RESET, 1, enter sweep on reset release when 1, idle when 0.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  push request; connects to datapath writeEn.
- x_in  in  7  pixel x.
- y_in  in  7  pixel y.
- c_in  in  3  pixel colour.
- clr_start  in  1  single-cycle request for a full-screen black sweep.
- x_out  out  7  pixel x to adapter.
- y_out  out  7  pixel y to adapter.
- c_out  out  3  colour to adapter.
- plot  out  1  adapter write enable; qualifies x_out/y_out/c_out.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- overflow  out  1  sticky: a push was dropped since reset.
- clr_busy  out  1  sweep in progress.

Behaviour:
- Reset (resetn=0, asynchronous):
  - FIFO emptied.
  - plot=0; x_out, y_out, c_out = 0.
  - full=0, empty=1, overflow=0.
  - State = S_SWEEP with clr_busy=1 when CLEAR_ON_RESET=1, else S_IDLE with clr_busy=0.
  - Sweep counters = 0.
- Reset mid-sweep or mid-drain: everything returns to reset values; nothing resumes.
- All outputs are registered.
- Push:
  - Accepted on a clk edge when wr_en=1 and full=0, in any state.
  - When wr_en=1 and full=1, the write is dropped and overflow sets; overflow clears only on reset.
  - Full is evaluated before any same-cycle pop, so a push at full is dropped even if a pop occurs that cycle.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read/write pointers and a (log2(DEPTH)+1)-bit count.
  - Pointers wrap DEPTH-1→0.
  - full = (count==DEPTH); empty = (count==0).
  - Simultaneous accepted push and pop leaves count unchanged.
- S_IDLE (drain):
  - When empty=0, pop one entry per cycle.
  - On the next edge: x_out/y_out/c_out = popped entry, plot=1.
  - When empty=1, plot=0 and x_out/y_out/c_out hold their last values.
  - Latency: a push into an empty FIFO at edge N appears with plot=1 after edge N+1.
  - Back-to-back pushes produce back-to-back plot cycles.
- clr_start:
  - Sampled only in S_IDLE. If it arrives with a pop pending, that pop still completes this cycle; the sweep starts the next cycle.
  - Ignored in S_SWEEP; requests are not queued.
- S_SWEEP:
  - No pops. Pushes are still accepted up to DEPTH.
  - Each cycle emits plot=1, c_out=3'b000, x_out=sx, y_out=sy.
  - sx increments every cycle; at WIDTH-1 it wraps to 0 and sy increments.
  - After emitting (WIDTH-1, HEIGHT-1): return to S_IDLE, clr_busy=0, sx=sy=0.
  - A sweep is exactly WIDTH*HEIGHT plot cycles (15360 at defaults).
  - clr_busy=1 for the whole sweep, deasserting on the edge after the last sweep pixel.
  - Queued entries drain immediately after the sweep, so sprites drawn during a clear land on top of it.
- Upstream contract: the drawing FSM need not stall when full is low. At defaults, one 4x4 box (16 writes) fits exactly into an empty FIFO.

Decomposition:
- Shared package:
  - Coordinate width (7) and colour width (3).
  - Colour constant BLACK=3'b000.
  - State encoding S_IDLE, S_SWEEP.
  - Default screen dimensions 128x120, shared with the bounce logic's edge limits.
- One sub-module: pixel_fifo.
  - Parameterised DEPTH and data width 17 (x,y,c packed).
  - Ports: push, pop, din, dout, full, empty.
  - Owns the pointers and count.
- The top level owns the sweep FSM, the output registers and overflow.

Test Plan:
- Reset with CLEAR_ON_RESET=1, no pushes:
  - 15360 consecutive plot=1 cycles with c_out=0, starting (0,0), row-major, ending (127,119).
  - clr_busy then drops and plot=0.
- After sweep, push (5,9,c=3'b101) one cycle:
  - Exactly one plot cycle on the following cycle with x_out=5, y_out=9, c_out=5.
  - empty=1 afterwards.
- In S_SWEEP, push 16 pixels (x=0..15, y=0, c=2), then a 17th:
  - full=1, overflow=1, 17th dropped.
  - After sweep ends, exactly 16 plots with x=0..15 in order.
- In S_IDLE with 3 entries queued, pulse clr_start:
  - The in-flight pop completes, then a full sweep runs.
  - The remaining 2 entries plot afterward in order.
- Assert resetn=0 midway through a 10-entry drain:
  - plot=0 and empty=1 immediately (async); overflow=0.
  - Sweep restarts at (0,0) on release.
- Continuous wr_en for 40 cycles in S_IDLE:
  - 40 plots and no overflow, since pop rate matches push rate.
